// File: rtl/branch_metric.sv
// Viterbi branch metric stage: Hamming distance of two sliced symbols to every
// candidate codeword (rate 1/2 or 1/3), two-stage pipeline with end-of-data forwarding.
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module branch_metric #(
  parameter int SLICED_INPUT_NUM = 6,
  parameter int SYM_W            = 3,
  parameter int NUM_CW           = 8,
  parameter int DIST_W           = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_bm,
  input  logic                        i_code_rate,
  input  logic [SLICED_INPUT_NUM-1:0] i_rx,
  input  logic                        i_ood,
  output logic [NUM_CW*DIST_W-1:0]    o_bm_a,
  output logic [NUM_CW*DIST_W-1:0]    o_bm_b,
  output logic                        o_bm_valid,
  output logic                        o_ood,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic             sample, stall, latch_rate;
  logic             rate_q;
  logic             s1_valid, s2_valid;
  logic [SYM_W-1:0] s1_a, s1_b;

  // Rate 1/2 uses only the low SYM_W-1 bits of each slot; upper half of the
  // codeword table is unused and forced to zero.
  function automatic logic [NUM_CW*DIST_W-1:0] calc_bm(input logic rate3,
                                                       input logic [SYM_W-1:0] sym);
    logic [SYM_W-1:0]          s;
    logic [SYM_W-1:0]          d;
    logic [NUM_CW*DIST_W-1:0]  r;
    r = '0;
    s = rate3 ? sym : {1'b0, sym[SYM_W-2:0]};
    for (int c = 0; c < NUM_CW; c++) begin
      d = s ^ SYM_W'(c);
      if (rate3 || c < NUM_CW/2) r[c*DIST_W +: DIST_W] = DIST_W'($countones(d));
    end
    return r;
  endfunction

  always_comb begin
    state_nx   = state;
    sample     = 1'b0;
    stall      = 1'b0;
    latch_rate = 1'b0;
    case (state)
      IDLE: begin
        if (i_ood) begin
          state_nx = DONE;
        end else if (en_bm) begin
          state_nx   = RUN;
          sample     = 1'b1;
          latch_rate = 1'b1;
        end
      end
      RUN: begin
        if (!en_bm)      stall    = 1'b1;
        else if (i_ood)  state_nx = DRAIN;
        else             sample   = 1'b1;
      end
      // Nothing enters S1 in DRAIN, so an empty S1 means S2 empties at this edge.
      DRAIN:   if (!s1_valid) state_nx = DONE;
      DONE:    if (!en_bm)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rate_q   <= `CODE_RATE_2;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      o_bm_a   <= '0;
      o_bm_b   <= '0;
    end else begin
      state <= state_nx;
      if (latch_rate) rate_q <= i_code_rate;
      if (stall) begin
        // S1 keeps its word; S2 stops presenting so nothing is emitted twice.
        s2_valid <= 1'b0;
      end else begin
        s1_valid <= sample;
        if (sample) begin
          s1_a <= i_rx[SYM_W-1:0];
          s1_b <= i_rx[2*SYM_W-1:SYM_W];
        end
        s2_valid <= s1_valid;
        if (s1_valid) begin
          o_bm_a <= calc_bm(rate_q == `CODE_RATE_3, s1_a);
          o_bm_b <= calc_bm(rate_q == `CODE_RATE_3, s1_b);
        end
      end
    end
  end

  assign o_bm_valid = s2_valid;
  assign o_ood      = (state == DONE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_branch_metric.sv
// Self-checking bench for branch_metric: scoreboard of expected metric pairs
// plus per-scenario tasks for framing, stalls, rate latching and reset.
module tb_branch_metric;
  localparam logic RATE_2 = 1'b0;
  localparam logic RATE_3 = 1'b1;

  // Handshake: a word is taken on each rising edge where en_bm=1 and i_ood=0
  // while IDLE or RUN; each taken word yields exactly one o_bm_valid cycle.
  logic        clk = 1'b0;
  logic        rst;
  logic        en_bm;
  logic        i_code_rate;
  logic [5:0]  i_rx;
  logic        i_ood;
  logic [15:0] o_bm_a;
  logic [15:0] o_bm_b;
  logic        o_bm_valid;
  logic        o_ood;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = -100;
  logic frame_rate = RATE_2;
  logic [31:0] exp_q[$];

  branch_metric dut (
    .clk(clk), .rst(rst), .en_bm(en_bm), .i_code_rate(i_code_rate), .i_rx(i_rx),
    .i_ood(i_ood), .o_bm_a(o_bm_a), .o_bm_b(o_bm_b), .o_bm_valid(o_bm_valid),
    .o_ood(o_ood), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_bm(input logic rate, input logic [2:0] sym);
    logic [15:0] r;
    logic [2:0]  cw;
    int d;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      cw = 3'(c);
      d = 0;
      for (int b = 0; b < 3; b++)
        if ((rate == RATE_3 || b < 2) && sym[b] != cw[b]) d++;
      if (rate == RATE_2 && c >= 4) d = 0;
      r[c*2 +: 2] = 2'(d);
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst === 1'b1 && o_bm_valid === 1'b1) begin
      logic [31:0] exp;
      valid_cnt++;
      last_valid_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got a=%h b=%h, expected no output", o_bm_a, o_bm_b);
      end else begin
        exp = exp_q.pop_front();
        if ({o_bm_a, o_bm_b} !== exp) begin
          errors++;
          $display("FAIL bm_data: got a=%h b=%h, expected a=%h b=%h",
                   o_bm_a, o_bm_b, exp[31:16], exp[15:0]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic rate);
    i_code_rate = rate;
    frame_rate  = rate;
  endtask

  task automatic send(input logic [5:0] w);
    en_bm = 1'b1;
    i_ood = 1'b0;
    i_rx  = w;
    exp_q.push_back({model_bm(frame_rate, w[2:0]), model_bm(frame_rate, w[5:3])});
    tick();
  endtask

  task automatic end_frame(input bit had_data);
    int n;
    en_bm = 1'b1;
    i_ood = 1'b1;
    i_rx  = 6'($urandom_range(0, 63));
    tick();
    i_ood = 1'b0;
    n = 0;
    while (o_ood !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (o_ood !== 1'b1) begin
      errors++;
      $display("FAIL ood_timeout: o_ood=%b after %0d cycles, expected 1", o_ood, n);
    end else if (had_data && cyc != last_valid_cyc + 1) begin
      errors++;
      $display("FAIL ood_timing: o_ood rose in cycle %0d, expected %0d", cyc, last_valid_cyc + 1);
    end
    en_bm = 1'b0;
    tick();
    checks++;
    if (o_ood !== 1'b0) begin
      errors++;
      $display("FAIL ood_clear: o_ood=%b, expected 0", o_ood);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d metrics outstanding, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({o_bm_a, o_bm_b, o_bm_valid, o_ood, dbg_state} !== 36'd0) begin
      errors++;
      $display("FAIL reset_state: got a=%h b=%h v=%b ood=%b st=%0d, expected all 0",
               o_bm_a, o_bm_b, o_bm_valid, o_ood, dbg_state);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_rate2();
    int c0;
    start_frame(RATE_2);
    c0 = cyc;
    send(6'b000_011);
    checks++;
    if (o_bm_valid !== 1'b0) begin
      errors++;
      $display("FAIL rate2_early_valid: got %b, expected 0", o_bm_valid);
    end
    end_frame(1);
    checks++;
    if (last_valid_cyc != c0 + 2) begin
      errors++;
      $display("FAIL rate2_latency: valid in cycle %0d, expected %0d", last_valid_cyc, c0 + 2);
    end
    checks++;
    if (o_bm_a !== {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2} ||
        o_bm_b !== {2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd0}) begin
      errors++;
      $display("FAIL rate2_hold: got a=%h b=%h, expected a=0016 b=0094", o_bm_a, o_bm_b);
    end
  endtask

  task automatic test_rate3();
    start_frame(RATE_3);
    send(6'b101_111);
    end_frame(1);
    checks++;
    if (o_bm_a[15:14] !== 2'd0 || o_bm_a[1:0] !== 2'd3 || o_bm_b[11:10] !== 2'd0 ||
        o_bm_b[5:4] !== 2'd3 || o_bm_b[1:0] !== 2'd2) begin
      errors++;
      $display("FAIL rate3_entries: got a=%h b=%h, expected a7=0 a0=3 b5=0 b2=3 b0=2",
               o_bm_a, o_bm_b);
    end
  endtask

  task automatic test_stream();
    int c0, v0;
    start_frame(RATE_3);
    c0 = cyc;
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) send(6'($urandom_range(0, 63)));
    end_frame(1);
    checks++;
    if (valid_cnt - v0 != 4 || last_valid_cyc != c0 + 5) begin
      errors++;
      $display("FAIL stream_valids: got %0d valids ending cycle %0d, expected 4 ending %0d",
               valid_cnt - v0, last_valid_cyc, c0 + 5);
    end
  endtask

  task automatic test_stall();
    int v0;
    start_frame(RATE_2);
    v0 = valid_cnt;
    send(6'($urandom_range(0, 63)));
    send(6'($urandom_range(0, 63)));
    en_bm = 1'b0;
    i_rx  = 6'($urandom_range(0, 63));
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) begin
        checks++;
        if (o_bm_valid !== 1'b0) begin
          errors++;
          $display("FAIL stall_valid: got %b in stall cycle %0d, expected 0", o_bm_valid, i + 1);
        end
      end
    end
    send(6'($urandom_range(0, 63)));
    send(6'($urandom_range(0, 63)));
    end_frame(1);
    checks++;
    if (valid_cnt - v0 != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d valids, expected 4", valid_cnt - v0);
    end
  endtask

  task automatic test_rate_switch();
    start_frame(RATE_3);
    send(6'b110_101);
    send(6'b011_100);
    i_code_rate = RATE_2;
    send(6'b111_111);
    send(6'b100_100);
    end_frame(1);
    start_frame(RATE_2);
    send(6'b111_111);
    send(6'b100_110);
    end_frame(1);
  endtask

  task automatic test_ood_idle();
    int v0;
    v0 = valid_cnt;
    en_bm = 1'b1;
    i_ood = 1'b1;
    i_rx  = 6'b111_000;
    tick();
    i_ood = 1'b0;
    checks++;
    if (o_ood !== 1'b1) begin
      errors++;
      $display("FAIL ood_idle: o_ood=%b, expected 1", o_ood);
    end
    tick();
    tick();
    en_bm = 1'b0;
    tick();
    checks++;
    if (o_ood !== 1'b0 || valid_cnt != v0) begin
      errors++;
      $display("FAIL ood_idle_exit: o_ood=%b valids=%0d, expected 0 and 0", o_ood, valid_cnt - v0);
    end
  endtask

  task automatic test_back_to_back();
    int v0, n;
    start_frame(1'($urandom_range(0, 1)));
    v0 = valid_cnt;
    n  = $urandom_range(12, 24);
    for (int i = 0; i < n; i++) send(6'($urandom_range(0, 63)));
    end_frame(1);
    checks++;
    if (valid_cnt - v0 != n) begin
      errors++;
      $display("FAIL b2b_count: got %0d valids, expected %0d", valid_cnt - v0, n);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    start_frame(RATE_3);
    send(6'b010_001);
    rst   = 1'b0;
    en_bm = 1'b0;
    #1;
    checks++;
    if ({o_bm_a, o_bm_b, o_bm_valid, o_ood, dbg_state} !== 36'd0) begin
      errors++;
      $display("FAIL reset_mid: got a=%h b=%h v=%b ood=%b st=%0d, expected all 0",
               o_bm_a, o_bm_b, o_bm_valid, o_ood, dbg_state);
    end
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    v0 = valid_cnt;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (valid_cnt != v0 || o_bm_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop: got %0d valids a=%h, expected 0 valids a=0000", valid_cnt - v0, o_bm_a);
    end
  endtask

  initial begin
    rst = 1'b0;
    en_bm = 1'b0;
    i_code_rate = RATE_2;
    i_rx = '0;
    i_ood = 1'b0;
    test_reset();
    test_rate2();
    test_rate3();
    test_stream();
    test_stall();
    test_rate_switch();
    test_ood_idle();
    test_back_to_back();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
